// File: rtl/prog_loader_pkg.sv
// Shared constants and loader state encoding for the program loader.
package prog_loader_pkg;

  localparam int BITNESS = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } ld_state_e;

  // True in the states that accept bytes from the host stream.
  function automatic logic is_loading(ld_state_e s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program memory: 2^AW x 16, one synchronous write port, one asynchronous read port.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the loader masks unloaded words.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a length-prefixed image into program memory and
// serves instruction fetches, holding the processor until an image commits.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                 WORD_W = BITNESS,
  parameter int                 AW     = 8,
  parameter logic [INSTR_W-1:0] FILL   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               cpu_hold,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  output logic               ld_ready,
  output logic               ld_done,
  output logic               fault
);

  localparam int DEPTH = 1 << AW;

  ld_state_e          state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [7:0]         hi_q, hi_d;
  logic [WORD_W-1:0]  len_active_q, len_active_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               ld_ready_q, ld_ready_d;
  logic               ld_done_q, ld_done_d;
  logic               fault_q, fault_d;

  logic               xfer;
  logic [15:0]        hdr_n;
  logic               last_word;
  logic               ram_we;
  logic [INSTR_W-1:0] ram_rdata;

  // A start pulse always wins over a coincident byte, which is dropped.
  assign xfer      = ld_valid & ld_ready_q & ~ld_start;
  assign hdr_n     = {len_q[15:8], ld_data};
  assign last_word = (16'(addr_q) == (len_q - 16'd1));

  // State and all loader registers; any reset abandons a load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      addr_q       <= '0;
      hi_q         <= '0;
      len_active_q <= '0;
      cpu_hold_q   <= 1'b1;
      ld_ready_q   <= 1'b0;
      ld_done_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      hi_q         <= hi_d;
      len_active_q <= len_active_d;
      cpu_hold_q   <= cpu_hold_d;
      ld_ready_q   <= ld_ready_d;
      ld_done_q    <= ld_done_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state: walk header then data words; ld_start restarts from anywhere.
  always_comb begin
    state_d = state_q;
    if (ld_start) begin
      state_d = ST_HDR_HI;
    end else begin
      case (state_q)
        ST_HDR_HI:  if (xfer) state_d = ST_HDR_LO;
        ST_HDR_LO: begin
          if (xfer) begin
            if (hdr_n == 16'd0)          state_d = ST_RUN;
            else if (32'(hdr_n) > DEPTH) state_d = ST_ERR;
            else                         state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: if (xfer) state_d = ST_DATA_LO;
        ST_DATA_LO: if (xfer) state_d = last_word ? ST_RUN : ST_DATA_HI;
        default:    state_d = state_q;
      endcase
    end
  end

  // Datapath: header length capture, high-byte staging and RAM write address.
  always_comb begin
    len_d  = len_q;
    addr_d = addr_q;
    hi_d   = hi_q;
    ram_we = 1'b0;
    if (ld_start) begin
      addr_d = '0;
    end else if (xfer) begin
      case (state_q)
        ST_HDR_HI:  len_d[15:8] = ld_data;
        ST_HDR_LO:  len_d[7:0]  = ld_data;
        ST_DATA_HI: hi_d        = ld_data;
        ST_DATA_LO: begin
          ram_we = 1'b1;
          addr_d = addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs follow the next state so they are registered alongside it;
  // len_active and cpu_hold change on the same edge that enters RUN.
  always_comb begin
    cpu_hold_d   = (state_d != ST_RUN);
    ld_ready_d   = is_loading(state_d);
    ld_done_d    = (state_d == ST_RUN);
    fault_d      = (state_d == ST_ERR);
    len_active_d = (state_d == ST_RUN) ? WORD_W'(len_d) : '0;
  end

  prog_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_q),
    .wdata ({hi_q, ld_data}),
    .raddr (pc[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Full-width compare so wrapped or out-of-image addresses read as FILL.
  assign instruction = (pc < len_active_q) ? ram_rdata : FILL;

  assign cpu_hold = cpu_hold_q;
  assign ld_ready = ld_ready_q;
  assign ld_done  = ld_done_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expectations, a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_prog_loader;

  localparam logic [15:0] FILLV = 16'hF11F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] instruction;
  logic        cpu_hold, ld_ready, ld_done, fault;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;

  int tests = 0;
  int fails = 0;
  int xfers = 0;

  localparam int K_INSTR = 0, K_HOLD = 1, K_READY = 2, K_DONE = 3, K_FAULT = 4, K_XFER = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } chk_t;

  chk_t sb[$];

  prog_loader #(.WORD_W(16), .AW(8), .FILL(FILLV)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .cpu_hold    (cpu_hold),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Monitor: counts accepted bytes and drains the scoreboard on each falling edge.
  initial begin
    chk_t        c;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (ld_valid && ld_ready && !ld_start && rst_n) xfers++;
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.kind)
          K_INSTR: act = instruction;
          K_HOLD:  act = {15'd0, cpu_hold};
          K_READY: act = {15'd0, ld_ready};
          K_DONE:  act = {15'd0, ld_done};
          K_FAULT: act = {15'd0, fault};
          default: act = xfers[15:0];
        endcase
        tests++;
        if (act !== c.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  // Let the monitor consume queued checks, then realign to just after a rising edge.
  task automatic flush();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string name, input logic [15:0] a, input logic [15:0] exp);
    pc = a;
    expect_val(name, K_INSTR, exp);
    flush();
  endtask

  task automatic status(input string tag, input logic hold, input logic rdy,
                        input logic done, input logic flt);
    expect_val({tag, "_hold"},  K_HOLD,  {15'd0, hold});
    expect_val({tag, "_ready"}, K_READY, {15'd0, rdy});
    expect_val({tag, "_done"},  K_DONE,  {15'd0, done});
    expect_val({tag, "_fault"}, K_FAULT, {15'd0, flt});
    flush();
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  // Present one byte and hold it until the handshake completes (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic r;
    bit   ok;
    ok = 1'b0;
    ld_valid = 1'b1;
    ld_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = ld_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (gaps) begin
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] img[$];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    status("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    fetch("rst_pc0", 16'h0000, FILLV);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back three-word load
    xfers = 0;
    pulse_start();
    img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    send_stream(img, 1'b0);
    expect_val("b2b_xfers", K_XFER, 16'd8);
    status("b2b", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("b2b_pc0", 16'h0000, 16'h1234);
    fetch("b2b_pc1", 16'h0001, 16'hABCD);
    fetch("b2b_pc2", 16'h0002, 16'h0007);
    fetch("b2b_pc3", 16'h0003, FILLV);
    fetch("b2b_pcwrap", 16'h0100, FILLV);
    fetch("b2b_pcmax", 16'hFFFF, FILLV);

    // Same load with valid toggling
    xfers = 0;
    pulse_start();
    send_stream(img, 1'b1);
    expect_val("gap_xfers", K_XFER, 16'd8);
    status("gap", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("gap_pc0", 16'h0000, 16'h1234);
    fetch("gap_pc1", 16'h0001, 16'hABCD);
    fetch("gap_pc2", 16'h0002, 16'h0007);
    fetch("gap_pc3", 16'h0003, FILLV);

    // Oversize header faults
    pulse_start();
    img = '{8'h01, 8'h01};
    send_stream(img, 1'b0);
    status("err", 1'b1, 1'b0, 1'b0, 1'b1);
    fetch("err_pc0", 16'h0000, FILLV);
    repeat (3) @(posedge clk);
    #1;
    status("err_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_start();
    expect_val("err_clr_fault", K_FAULT, 16'd0);
    expect_val("err_clr_ready", K_READY, 16'd1);
    flush();
    img = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
    send_stream(img, 1'b0);
    status("rec", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("rec_pc0", 16'h0000, 16'h1111);
    fetch("rec_pc1", 16'h0001, 16'h2222);
    fetch("rec_pc2", 16'h0002, FILLV);

    // Full-depth image (N == DEPTH) is legal
    pulse_start();
    img = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      img.push_back(8'(i));
      img.push_back(~8'(i));
    end
    send_stream(img, 1'b0);
    status("full", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("full_pc0", 16'h0000, 16'h00FF);
    fetch("full_pc80", 16'h0080, 16'h807F);
    fetch("full_pc255", 16'h00FF, 16'hFF00);
    fetch("full_pc256", 16'h0100, FILLV);

    // Restart from RUN hides the old image until the new one commits
    pulse_start();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_stream(img, 1'b0);
    fetch("rerun_pc1", 16'h0001, 16'hABCD);
    pulse_start();
    status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
    fetch("restart_pc0", 16'h0000, FILLV);
    img = '{8'h00, 8'h01, 8'h55};
    send_stream(img, 1'b0);
    fetch("partial_pc0", 16'h0000, FILLV);
    img = '{8'hAA};
    send_stream(img, 1'b0);
    fetch("new_pc0", 16'h0000, 16'h55AA);
    fetch("new_pc1", 16'h0001, FILLV);

    // Asynchronous reset mid-stream
    pulse_start();
    img = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
    send_stream(img, 1'b0);
    #2;
    rst_n = 1'b0;
    expect_val("arst_hold",  K_HOLD,  16'd1);
    expect_val("arst_ready", K_READY, 16'd0);
    expect_val("arst_done",  K_DONE,  16'd0);
    expect_val("arst_fault", K_FAULT, 16'd0);
    flush();
    fetch("arst_pc0", 16'h0000, FILLV);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    img = '{8'h00, 8'h01, 8'h9A, 8'hBC};
    send_stream(img, 1'b0);
    status("post_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("post_rst_pc0", 16'h0000, 16'h9ABC);

    // Empty image
    pulse_start();
    img = '{8'h00, 8'h00};
    send_stream(img, 1'b0);
    status("empty", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("empty_pc0", 16'h0000, FILLV);
    fetch("empty_pc5", 16'h0005, FILLV);
    fetch("empty_pcmax", 16'hFFFF, FILLV);

    // Start coincident with a byte in DATA_HI: byte dropped, restart at header
    pulse_start();
    img = '{8'h00, 8'h01};
    send_stream(img, 1'b0);
    xfers = 0;
    ld_valid = 1'b1;
    ld_data  = 8'h7F;
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    status("coinc", 1'b1, 1'b1, 1'b0, 1'b0);
    img = '{8'h00, 8'h01, 8'hC3, 8'h3C};
    send_stream(img, 1'b0);
    expect_val("coinc_xfers", K_XFER, 16'd4);
    status("coinc_run", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("coinc_pc0", 16'h0000, 16'hC33C);
    fetch("coinc_pc1", 16'h0001, FILLV);

    flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
